// File: rtl/snake_head_mover.sv
// snake_head_mover: IDLE/RUN/DEAD head stepper on a GRID_W x GRID_H grid, one cell per TICK_DIV cycles.
// Define WRAP_EN to wrap around grid edges; by default an edge move kills the snake (wall_hit).
module snake_head_mover #(
   parameter int GRID_W   = 40,
   parameter int GRID_H   = 30,
   parameter int TICK_DIV = 5000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] direction,
   input  logic       enable,
   input  logic       restart,
   output logic [5:0] head_x,
   output logic [5:0] head_y,
   output logic       step,
   output logic       wall_hit,
   output logic [1:0] state
);
   typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DEAD = 2'b10} st_t;
   localparam logic [5:0]  X0 = 6'(GRID_W / 2);
   localparam logic [5:0]  Y0 = 6'(GRID_H / 2);
   localparam logic [5:0]  XM = 6'(GRID_W - 1);
   localparam logic [5:0]  YM = 6'(GRID_H - 1);
   localparam logic [23:0] TM = 24'(TICK_DIV - 1);
   st_t         st_q;
   logic [5:0]  x_q, y_q, x_d, y_d;
   logic [2:0]  hd_q, ld_q, cmp_dir;
   logic [23:0] cnt_q;
   logic        step_q, wall_q, legal, tick, rev;
   always_comb begin
      legal   = direction >= 3'd1 && direction <= 3'd4;
      tick    = st_q == RUN && enable && cnt_q == TM;
      // on a move edge the current heading becomes last_dir, so reversal is judged against it
      cmp_dir = tick ? hd_q : ld_q;
      rev     = {direction, cmp_dir} inside {6'o12, 6'o21, 6'o34, 6'o43};
      x_d     = hd_q == 3'd1 ? (x_q == 6'd0 ? XM : x_q - 6'd1) :
                hd_q == 3'd2 ? (x_q == XM ? 6'd0 : x_q + 6'd1) : x_q;
      y_d     = hd_q == 3'd3 ? (y_q == 6'd0 ? YM : y_q - 6'd1) :
                hd_q == 3'd4 ? (y_q == YM ? 6'd0 : y_q + 6'd1) : y_q;
   end
`ifndef WRAP_EN
   logic edge_hit;
   assign edge_hit = (hd_q == 3'd1 && x_q == 6'd0) || (hd_q == 3'd2 && x_q == XM) ||
                     (hd_q == 3'd3 && y_q == 6'd0) || (hd_q == 3'd4 && y_q == YM);
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q   <= IDLE;
         x_q    <= X0;
         y_q    <= Y0;
         hd_q   <= 3'd0;
         ld_q   <= 3'd0;
         cnt_q  <= '0;
         step_q <= 1'b0;
         wall_q <= 1'b0;
      end else if (restart) begin
         st_q   <= IDLE;
         x_q    <= X0;
         y_q    <= Y0;
         hd_q   <= 3'd0;
         ld_q   <= 3'd0;
         cnt_q  <= '0;
         step_q <= 1'b0;
         wall_q <= 1'b0;
      end else begin
         step_q <= 1'b0;
         case (st_q)
            IDLE: if (enable && legal) begin
               st_q  <= RUN;
               hd_q  <= direction;
               ld_q  <= direction;
               cnt_q <= '0;
            end
            RUN: begin
               if (legal && !rev) hd_q <= direction;
               if (enable) cnt_q <= tick ? '0 : cnt_q + 24'd1;
               if (tick) begin
                  ld_q <= hd_q;
`ifdef WRAP_EN
                  x_q    <= x_d;
                  y_q    <= y_d;
                  step_q <= 1'b1;
`else
                  if (edge_hit) begin
                     st_q   <= DEAD;
                     wall_q <= 1'b1;
                  end else begin
                     x_q    <= x_d;
                     y_q    <= y_d;
                     step_q <= 1'b1;
                  end
`endif
               end
            end
            DEAD: ;
            default: st_q <= IDLE;
         endcase
      end
   end
   assign head_x   = x_q;
   assign head_y   = y_q;
   assign step     = step_q;
   assign wall_hit = wall_q;
   assign state    = st_q;
endmodule

// File: tb/tb_snake_head_mover.sv
// tb_snake_head_mover: directed stimulus, per-cycle check against a grid-level behavioural model.
module tb_snake_head_mover;
   localparam int W = 40, H = 30, TD = 4;
   logic       clk = 1'b0, rst_n = 1'b0, enable = 1'b0, restart = 1'b0;
   logic [2:0] direction = 3'd0;
   logic [5:0] head_x, head_y;
   logic       step, wall_hit;
   logic [1:0] state;
   int vectors = 0, miscompares = 0;
   bit chk_on = 1'b0;

   snake_head_mover #(.GRID_W(W), .GRID_H(H), .TICK_DIV(TD)) dut (
      .clk(clk), .rst_n(rst_n), .direction(direction), .enable(enable), .restart(restart),
      .head_x(head_x), .head_y(head_y), .step(step), .wall_hit(wall_hit), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct {
      int st, x, y, hd, ld, cnt;
      bit stp, wall;
   } mdl_t;
   mdl_t m;

   function automatic mdl_t rst_m();
      mdl_t n;
      n.st = 0; n.x = W / 2; n.y = H / 2; n.hd = 0; n.ld = 0; n.cnt = 0; n.stp = 0; n.wall = 0;
      return n;
   endfunction

   // opposite = different directions on the same axis (left/right or up/down)
   function automatic bit opposite(int a, int b);
      return a != b && a >= 1 && b >= 1 && (a - 1) / 2 == (b - 1) / 2;
   endfunction

   function automatic mdl_t nxt(mdl_t s, int dir, bit en, bit rs);
      mdl_t n = s;
      bit legal = dir >= 1 && dir <= 4;
      bit tick;
      int dx, dy, tx, ty;
      n.stp = 0;
      if (rs) return rst_m();
      if (s.st == 0) begin
         if (en && legal) begin n.st = 1; n.hd = dir; n.ld = dir; n.cnt = 0; end
      end else if (s.st == 1) begin
         tick = en && s.cnt == TD - 1;
         if (legal && !opposite(dir, tick ? s.hd : s.ld)) n.hd = dir;
         if (en) n.cnt = tick ? 0 : s.cnt + 1;
         if (tick) begin
            dx = s.hd == 1 ? -1 : s.hd == 2 ? 1 : 0;
            dy = s.hd == 3 ? -1 : s.hd == 4 ? 1 : 0;
            tx = s.x + dx;
            ty = s.y + dy;
            n.ld = s.hd;
`ifdef WRAP_EN
            n.x = (tx + W) % W; n.y = (ty + H) % H; n.stp = 1;
`else
            if (tx < 0 || tx >= W || ty < 0 || ty >= H) begin n.st = 2; n.wall = 1; end
            else begin n.x = tx; n.y = ty; n.stp = 1; end
`endif
         end
      end
      return n;
   endfunction

   always @(posedge clk or negedge rst_n)
      if (!rst_n) m <= rst_m();
      else m <= nxt(m, int'(direction), enable, restart);

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) if (chk_on) begin
      chk("model_x", int'(head_x), m.x);
      chk("model_y", int'(head_y), m.y);
      chk("model_step", int'(step), int'(m.stp));
      chk("model_wall", int'(wall_hit), int'(m.wall));
      chk("model_state", int'(state), m.st);
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      cyc(2);
      rst_n = 1'b1;
      chk_on = 1'b1;
      cyc(1);
      chk("rst_x", int'(head_x), 20); chk("rst_y", int'(head_y), 15);
      chk("rst_state", int'(state), 0); chk("rst_step", int'(step), 0); chk("rst_wall", int'(wall_hit), 0);
      enable = 1'b1; direction = 3'd2;
      cyc(1); chk("run_state", int'(state), 1);
      cyc(4); chk("move1_x", int'(head_x), 21); chk("move1_step", int'(step), 1);
      cyc(1); chk("step_once", int'(step), 0);
      cyc(3); chk("move2_x", int'(head_x), 22);
      direction = 3'd1;
      cyc(4); chk("rev_x", int'(head_x), 23); chk("rev_y", int'(head_y), 15);
      direction = 3'd3;
      cyc(4); chk("up_x", int'(head_x), 23); chk("up_y", int'(head_y), 14);
      direction = 3'd2;
      cyc(64); chk("edge_x", int'(head_x), 39);
      cyc(4);
`ifdef WRAP_EN
      chk("wrap_x", int'(head_x), 0); chk("wrap_step", int'(step), 1);
      chk("wrap_state", int'(state), 1); chk("wrap_wall", int'(wall_hit), 0);
`else
      chk("wall_x", int'(head_x), 39); chk("wall_step", int'(step), 0);
      chk("wall_state", int'(state), 2); chk("wall_hit", int'(wall_hit), 1);
      direction = 3'd4;
      cyc(5); chk("dead_y", int'(head_y), 14); chk("dead_state", int'(state), 2);
      direction = 3'd2;
`endif
      restart = 1'b1;
      cyc(1); chk("restart_x", int'(head_x), 20); chk("restart_state", int'(state), 0);
      chk("restart_wall", int'(wall_hit), 0);
      restart = 1'b0;
      cyc(4);
      restart = 1'b1;
      cyc(1); chk("rs_tick_x", int'(head_x), 20); chk("rs_tick_step", int'(step), 0);
      chk("rs_tick_state", int'(state), 0);
      restart = 1'b0;
      cyc(3);
      enable = 1'b0;
      cyc(10); chk("pause_x", int'(head_x), 20); chk("pause_state", int'(state), 1);
      enable = 1'b1;
      cyc(2); chk("resume_x", int'(head_x), 21); chk("resume_step", int'(step), 1);
      cyc(2);
      #1 rst_n = 1'b0;
      #1 chk("arst_x", int'(head_x), 20); chk("arst_state", int'(state), 0);
      enable = 1'b0; direction = 3'd0;
      cyc(1);
      rst_n = 1'b1;
      enable = 1'b1;
      cyc(6); chk("post_rst_state", int'(state), 0); chk("post_rst_step", int'(step), 0);
      direction = 3'd4;
      cyc(5); chk("post_rst_y", int'(head_y), 16);
      chk_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
